// File: rtl/pixel_gen_pkg.sv
// Shared types and helpers for pixel_pattern_gen: display modes, colour-bar table
// and the channel widening function.
package pixel_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_IMAGE = 2'd3
  } mode_e;

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Widen a w-bit channel held in the low bits of v to 8 bits by repeating its pattern.
  function automatic logic [7:0] expand_chan(input logic [7:0] v, input int w);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[3'(7 - i)] = v[3'(w - 1 - (i % w))];
    end
    return r;
  endfunction

endpackage

// File: rtl/pg_sync_delay.sv
// Parametrised-depth shift register that keeps the sync/video_on sideband
// aligned with the pixel pipeline.
module pg_sync_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];

  // Next state: new sample enters stage 0, every other stage takes its predecessor.
  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Shift register state with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/pixel_pattern_gen.sv
// Run-time selectable test pattern generator (solid, bars, checker, scaled ROM image)
// with a fixed 3-edge pipeline. Define PIXEL_GEN_SCROLL_EN to scroll content 1 pixel per frame.
module pixel_pattern_gen
  import pixel_gen_pkg::*;
#(
  parameter int          CNT_W       = 11,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          COLOR_W     = 4,
  parameter int          IMG_W       = 320,
  parameter int          IMG_H       = 240,
  parameter int          SCALE_SHIFT = 1,
  parameter int          ADDR_W      = 17,
  parameter int          CHK_SHIFT   = 5,
  parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
  input  logic                   rfr_clk,
  input  logic                   reset,
  input  logic                   video_on,
  input  logic [CNT_W-1:0]       pixel_cnt,
  input  logic [CNT_W-1:0]       line_cnt,
  input  logic                   h_sync,
  input  logic                   v_sync,
  input  logic [1:0]             mode_sel,
  input  logic [23:0]            solid_rgb,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [3*COLOR_W-1:0]   rom_data,
  output logic [7:0]             p_red,
  output logic [7:0]             p_green,
  output logic [7:0]             p_blue,
  output logic                   p_h_sync,
  output logic                   p_v_sync,
  output logic                   p_video_on,
  output logic [7:0]             frame_cnt
);

  localparam int BAR_W = H_ACTIVE / 8;

  mode_e             active_mode_q, active_mode_d, mode_now;
  logic [23:0]       active_rgb_q, active_rgb_d, rgb_now;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [23:0]       rgb1_q, rgb1_d, rgb2_q, rgb2_d, pix_q, pix_d;
  logic              use_rom1_q, use_rom1_d, use_rom2_q, use_rom2_d;
  logic              fs, in_area, img_hit;
  logic [CNT_W-1:0]  x, sx_raw, sx, sy;
  logic [2:0]        bar_idx;
  logic [2:0]        sb_out;

  // Stage-1 pattern decode, mode/colour capture at frame start, frame counter and later stages.
  always_comb begin
    fs = (pixel_cnt == {CNT_W{1'b0}}) && (line_cnt == {CNT_W{1'b0}});
    if (fs) begin
      mode_now    = mode_e'(mode_sel);
      rgb_now     = solid_rgb;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      mode_now    = active_mode_q;
      rgb_now     = active_rgb_q;
      frame_cnt_d = frame_cnt_q;
    end
    active_mode_d = mode_now;
    active_rgb_d  = rgb_now;

    sx_raw = pixel_cnt >> SCALE_SHIFT;
    sy     = line_cnt >> SCALE_SHIFT;
`ifdef PIXEL_GEN_SCROLL_EN
    x  = CNT_W'((32'(pixel_cnt) + 32'(frame_cnt_d)) % 32'(H_ACTIVE));
    sx = CNT_W'((32'(sx_raw) + 32'(frame_cnt_d)) % 32'(IMG_W));
`else
    x  = pixel_cnt;
    sx = sx_raw;
`endif

    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (32'(x) >= 32'(k * BAR_W)) begin
        bar_idx = bar_idx + 3'd1;
      end else begin
        bar_idx = bar_idx;
      end
    end

    in_area = video_on && (pixel_cnt < CNT_W'(H_ACTIVE)) && (line_cnt < CNT_W'(V_ACTIVE));
    img_hit = (32'(sx_raw) < 32'(IMG_W)) && (32'(sy) < 32'(IMG_H));

    rgb1_d     = 24'h000000;
    use_rom1_d = 1'b0;
    rom_addr_d = {ADDR_W{1'b0}};
    if (in_area) begin
      case (mode_now)
        MODE_SOLID: rgb1_d = rgb_now;
        MODE_BARS:  rgb1_d = BAR_RGB[bar_idx];
        MODE_CHECK: rgb1_d = (x[CHK_SHIFT] ^ line_cnt[CHK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
        MODE_IMAGE: begin
          if (img_hit) begin
            use_rom1_d = 1'b1;
            rom_addr_d = ADDR_W'(32'(sy) * 32'(IMG_W) + 32'(sx));
          end else begin
            rgb1_d = BORDER_RGB;
          end
        end
        default: rgb1_d = 24'h000000;
      endcase
    end else begin
      rgb1_d     = 24'h000000;
      use_rom1_d = 1'b0;
    end

    // Stage 2 only waits for the ROM; the output stage picks ROM data or the padded colour.
    rgb2_d     = rgb1_q;
    use_rom2_d = use_rom1_q;
    if (use_rom2_q) begin
      pix_d = {expand_chan(8'(rom_data[3*COLOR_W-1 -: COLOR_W]), COLOR_W),
               expand_chan(8'(rom_data[2*COLOR_W-1 -: COLOR_W]), COLOR_W),
               expand_chan(8'(rom_data[COLOR_W-1 -: COLOR_W]), COLOR_W)};
    end else begin
      pix_d = rgb2_q;
    end
  end

  // Pipeline, capture and counter registers; reset takes priority over frame start.
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      active_mode_q <= MODE_SOLID;
      active_rgb_q  <= 24'h000000;
      frame_cnt_q   <= 8'h00;
      rom_addr_q    <= {ADDR_W{1'b0}};
      rgb1_q        <= 24'h000000;
      use_rom1_q    <= 1'b0;
      rgb2_q        <= 24'h000000;
      use_rom2_q    <= 1'b0;
      pix_q         <= 24'h000000;
    end else begin
      active_mode_q <= active_mode_d;
      active_rgb_q  <= active_rgb_d;
      frame_cnt_q   <= frame_cnt_d;
      rom_addr_q    <= rom_addr_d;
      rgb1_q        <= rgb1_d;
      use_rom1_q    <= use_rom1_d;
      rgb2_q        <= rgb2_d;
      use_rom2_q    <= use_rom2_d;
      pix_q         <= pix_d;
    end
  end

  pg_sync_delay #(.DEPTH(3), .WIDTH(3)) u_sync_delay (
    .clk   (rfr_clk),
    .reset (reset),
    .din   ({h_sync, v_sync, video_on}),
    .dout  (sb_out)
  );

  assign rom_addr   = rom_addr_q;
  assign frame_cnt  = frame_cnt_q;
  assign p_red      = pix_q[23:16];
  assign p_green    = pix_q[15:8];
  assign p_blue     = pix_q[7:0];
  assign p_h_sync   = sb_out[2];
  assign p_v_sync   = sb_out[1];
  assign p_video_on = sb_out[0];

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Randomised scoreboard bench for pixel_pattern_gen on a reduced 64x8 raster with a
// behavioural reference model and a synchronous ROM model.
`timescale 1ns/1ps
module tb_pixel_pattern_gen;

  localparam int CNT_W = 11, H_ACTIVE = 64, V_ACTIVE = 8, COLOR_W = 4;
  localparam int IMG_W = 20, IMG_H = 3, SCALE_SHIFT = 1, ADDR_W = 17, CHK_SHIFT = 2;
  localparam logic [23:0] BORDER_RGB = 24'h123456;
  localparam int H_TOT = 72, V_TOT = 10, ROM_N = IMG_W * IMG_H;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk = 1'b0;
  logic reset, video_on, h_sync, v_sync;
  logic [CNT_W-1:0] pixel_cnt, line_cnt;
  logic [1:0] mode_sel;
  logic [23:0] solid_rgb;
  logic [ADDR_W-1:0] rom_addr;
  logic [3*COLOR_W-1:0] rom_data;
  logic [7:0] p_red, p_green, p_blue, frame_cnt;
  logic p_h_sync, p_v_sync, p_video_on;

  logic [11:0] rom_mem [ROM_N];

  typedef struct { int due; logic [23:0] rgb; logic [2:0] sb; } pix_t;
  typedef struct { int due; logic [ADDR_W-1:0] addr; logic [7:0] fc; } adr_t;
  pix_t pix_q [$];
  adr_t adr_q [$];

  int edges = 0, checks = 0, errors = 0;
  int m_mode = 0, m_fc = 0;
  logic [23:0] m_rgb = 24'h0;

  always #5 clk = ~clk;

  pixel_pattern_gen #(
    .CNT_W(CNT_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .COLOR_W(COLOR_W),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SHIFT(SCALE_SHIFT), .ADDR_W(ADDR_W),
    .CHK_SHIFT(CHK_SHIFT), .BORDER_RGB(BORDER_RGB)
  ) dut (
    .rfr_clk(clk), .reset(reset), .video_on(video_on), .pixel_cnt(pixel_cnt),
    .line_cnt(line_cnt), .h_sync(h_sync), .v_sync(v_sync), .mode_sel(mode_sel),
    .solid_rgb(solid_rgb), .rom_addr(rom_addr), .rom_data(rom_data),
    .p_red(p_red), .p_green(p_green), .p_blue(p_blue), .p_h_sync(p_h_sync),
    .p_v_sync(p_v_sync), .p_video_on(p_video_on), .frame_cnt(frame_cnt)
  );

  // Synchronous image ROM: data appears one edge after the address.
  always @(posedge clk) begin
    if (int'(rom_addr) < ROM_N) rom_data <= rom_mem[int'(rom_addr)];
    else rom_data <= 12'h000;
  end

  // Expected pixel per the pattern rules, computed with plain arithmetic.
  function automatic void model(input int pc, input int lc, input bit vo,
                                output logic [23:0] er, output int ea);
    int x, sx, sy, r, g, b;
    logic [11:0] w;
    er = 24'h0;
    ea = 0;
    if (vo && pc < H_ACTIVE && lc < V_ACTIVE) begin
      x = pc;
`ifdef PIXEL_GEN_SCROLL_EN
      x = (pc + m_fc) % H_ACTIVE;
`endif
      case (m_mode)
        0: er = m_rgb;
        1: er = BARS[x / (H_ACTIVE / 8)];
        2: er = ((((x >> CHK_SHIFT) ^ (lc >> CHK_SHIFT)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
        default: begin
          sx = pc >> SCALE_SHIFT;
          sy = lc >> SCALE_SHIFT;
          if (sx < IMG_W && sy < IMG_H) begin
`ifdef PIXEL_GEN_SCROLL_EN
            sx = (sx + m_fc) % IMG_W;
`endif
            ea = sy * IMG_W + sx;
            w = rom_mem[ea];
            r = int'(w[11:8]) * 17;
            g = int'(w[7:4]) * 17;
            b = int'(w[3:0]) * 17;
            er = {8'(r), 8'(g), 8'(b)};
          end else begin
            er = BORDER_RGB;
          end
        end
      endcase
    end
  endfunction

  task automatic drive(input int pc, input int lc, input bit vo, input bit hs, input bit vs,
                       input bit rst, input logic [1:0] ms, input logic [23:0] srgb);
    int s, ea;
    logic [23:0] er;
    @(negedge clk);
    pixel_cnt = CNT_W'(pc);
    line_cnt  = CNT_W'(lc);
    video_on  = vo;
    h_sync    = hs;
    v_sync    = vs;
    reset     = rst;
    mode_sel  = ms;
    solid_rgb = srgb;
    s = edges + 1;
    if (rst) begin
      m_mode = 0;
      m_rgb  = 24'h0;
      m_fc   = 0;
      foreach (pix_q[i]) begin
        if (pix_q[i].due >= s) begin
          pix_q[i].rgb = 24'h0;
          pix_q[i].sb  = 3'b000;
        end
      end
      pix_q.push_back('{s + 2, 24'h0, 3'b000});
      adr_q.push_back('{s, {ADDR_W{1'b0}}, 8'h00});
    end else begin
      if (pc == 0 && lc == 0) begin
        m_mode = int'(ms);
        m_rgb  = srgb;
        m_fc   = (m_fc + 1) % 256;
      end
      model(pc, lc, vo, er, ea);
      pix_q.push_back('{s + 2, er, {hs, vs, vo}});
      adr_q.push_back('{s, ADDR_W'(ea), 8'(m_fc)});
    end
  endtask

  // Monitor: after every edge, compare whatever the scoreboard expects at this edge.
  always begin
    pix_t p;
    adr_t a;
    @(posedge clk);
    edges = edges + 1;
    #1;
    while (adr_q.size() > 0 && adr_q[0].due <= edges) begin
      a = adr_q.pop_front();
      checks = checks + 2;
      if (rom_addr !== a.addr) begin
        errors = errors + 1;
        $display("FAIL rom_addr edge=%0d got=%0d want=%0d", edges, rom_addr, a.addr);
      end
      if (frame_cnt !== a.fc) begin
        errors = errors + 1;
        $display("FAIL frame_cnt edge=%0d got=%0d want=%0d", edges, frame_cnt, a.fc);
      end
    end
    while (pix_q.size() > 0 && pix_q[0].due <= edges) begin
      p = pix_q.pop_front();
      checks = checks + 2;
      if ({p_red, p_green, p_blue} !== p.rgb) begin
        errors = errors + 1;
        $display("FAIL pixel edge=%0d got=%06h want=%06h", edges, {p_red, p_green, p_blue}, p.rgb);
      end
      if ({p_h_sync, p_v_sync, p_video_on} !== p.sb) begin
        errors = errors + 1;
        $display("FAIL sideband edge=%0d got=%03b want=%03b", edges,
                 {p_h_sync, p_v_sync, p_video_on}, p.sb);
      end
    end
  end

  initial begin
    bit act, vo, rst;
    logic [1:0] ms;
    reset = 1'b1; video_on = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
    pixel_cnt = '0; line_cnt = '0; mode_sel = 2'd0; solid_rgb = 24'h0;
    foreach (rom_mem[i]) rom_mem[i] = 12'($urandom);
    rom_mem[41] = 12'hA5F;

    repeat (3) drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 24'h0);
    for (int f = 0; f < 12; f++) begin
      for (int lc = 0; lc < V_TOT; lc++) begin
        for (int pc = 0; pc < H_TOT; pc++) begin
          act = (pc < H_ACTIVE) && (lc < V_ACTIVE);
          vo = act;
          if ($urandom_range(15) == 0) vo = !vo;
          ms = (pc == 0 && lc == 0) ? 2'(f % 4) : 2'($urandom);
          rst = (f == 5) && (lc == 3) && (pc == 20 || pc == 21);
          drive(pc, lc, vo, 1'($urandom), 1'($urandom), rst, ms, 24'($urandom));
        end
      end
    end
    // Back-to-back frame starts walk frame_cnt through its 255 -> 0 wrap.
    repeat (300) drive(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                       2'($urandom), 24'($urandom));
    repeat (4) @(negedge clk);

    checks = checks + 1;
    if (pix_q.size() != 0 || adr_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain got=%0d want=0 pending", pix_q.size() + adr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
